// File: rtl/stk_rsp_q.sv
// Per-engine response queue between the WRBK stage and the client engines.
// Each engine owns a small FIFO of {is_pop, err, dat} plus a sticky overflow flag.
module stk_rsp_q #(
    parameter int ENGS_N = 4,
    parameter int DAT_W  = 128,
    parameter int DEPTH  = 2
) (
    input  logic                            clk,
    input  logic                            arst,
    input  logic                            i_wrbk_vld,
    input  logic [$clog2(ENGS_N)-1:0]       i_wrbk_engid,
    input  logic                            i_wrbk_is_pop,
    input  logic                            i_wrbk_err,
    input  logic [DAT_W-1:0]                i_wrbk_dat,
    output logic [ENGS_N-1:0]               o_ad_full,
    output logic [ENGS_N-1:0]               o_rsp_vld,
    output logic [ENGS_N-1:0]               o_rsp_is_pop,
    output logic [ENGS_N-1:0]               o_rsp_err,
    output logic [ENGS_N-1:0][DAT_W-1:0]    o_rsp_dat,
    input  logic [ENGS_N-1:0]               i_rsp_ack,
    output logic [ENGS_N-1:0]               o_ovf_r
);

    localparam int ENG_W = $clog2(ENGS_N);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Push completions carry no payload, so store zero data for them.
    logic [DAT_W-1:0] wr_dat;
    assign wr_dat = i_wrbk_is_pop ? i_wrbk_dat : '0;

    for (genvar e = 0; e < ENGS_N; e++) begin : g_eng
        logic [PTR_W-1:0] rd_ptr;
        logic [PTR_W-1:0] wr_ptr;
        logic [CNT_W-1:0] cnt;
        logic             ovf_r;
        logic             wr_hit;
        logic             pop;
        logic             full;
        logic             wr_acc;
        logic             vld;
        logic [DAT_W-1:0] mem_dat [DEPTH];
        logic [DEPTH-1:0] mem_pop;
        logic [DEPTH-1:0] mem_err;

        assign vld    = (cnt != '0);
        assign full   = (cnt == CNT_W'(DEPTH));
        assign wr_hit = i_wrbk_vld && (i_wrbk_engid == ENG_W'(e));
        assign pop    = i_rsp_ack[e] && vld;
        // A full queue still accepts a write when its head leaves in the same cycle.
        assign wr_acc = wr_hit && (!full || pop);

        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        always_ff @(posedge clk or posedge arst) begin
            if (arst) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                cnt    <= '0;
                ovf_r  <= 1'b0;
            end else begin
                if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)    rd_ptr <= rd_ptr + PTR_W'(1);
                cnt <= cnt + CNT_W'(wr_acc) - CNT_W'(pop);
                if (wr_hit && !wr_acc) ovf_r <= 1'b1;
            end
        end

        // NOTE: storage is deliberately left out of reset; occupancy alone decides
        // what is visible, and the output masking hides stale contents.
        always_ff @(posedge clk) begin
            if (wr_acc) begin
                mem_dat[wr_ptr] <= wr_dat;
                mem_pop[wr_ptr] <= i_wrbk_is_pop;
                mem_err[wr_ptr] <= i_wrbk_err;
            end
        end

        assign o_rsp_vld[e]    = vld;
        assign o_ad_full[e]    = full;
        assign o_ovf_r[e]      = ovf_r;
        assign o_rsp_is_pop[e] = vld && mem_pop[rd_ptr];
        assign o_rsp_err[e]    = vld && mem_err[rd_ptr];
        assign o_rsp_dat[e]    = vld ? mem_dat[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_stk_rsp_q.sv
// Directed bench for stk_rsp_q: a vector table for single-cycle behaviour plus
// hand-written sequences for overflow-with-ack, pointer wrap and mid-run reset.
module tb_stk_rsp_q;

    localparam int ENGS_N = 4;
    localparam int DAT_W  = 128;
    localparam int DEPTH  = 2;

    logic                         clk;
    logic                         arst;
    logic                         i_wrbk_vld;
    logic [1:0]                   i_wrbk_engid;
    logic                         i_wrbk_is_pop;
    logic                         i_wrbk_err;
    logic [DAT_W-1:0]             i_wrbk_dat;
    logic [ENGS_N-1:0]            o_ad_full;
    logic [ENGS_N-1:0]            o_rsp_vld;
    logic [ENGS_N-1:0]            o_rsp_is_pop;
    logic [ENGS_N-1:0]            o_rsp_err;
    logic [ENGS_N-1:0][DAT_W-1:0] o_rsp_dat;
    logic [ENGS_N-1:0]            i_rsp_ack;
    logic [ENGS_N-1:0]            o_ovf_r;

    int n_checks = 0;
    int n_pass   = 0;

    stk_rsp_q #(.ENGS_N(ENGS_N), .DAT_W(DAT_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .arst         (arst),
        .i_wrbk_vld   (i_wrbk_vld),
        .i_wrbk_engid (i_wrbk_engid),
        .i_wrbk_is_pop(i_wrbk_is_pop),
        .i_wrbk_err   (i_wrbk_err),
        .i_wrbk_dat   (i_wrbk_dat),
        .o_ad_full    (o_ad_full),
        .o_rsp_vld    (o_rsp_vld),
        .o_rsp_is_pop (o_rsp_is_pop),
        .o_rsp_err    (o_rsp_err),
        .o_rsp_dat    (o_rsp_dat),
        .i_rsp_ack    (i_rsp_ack),
        .o_ovf_r      (o_ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic [1:0]       eng;
        logic             is_pop;
        logic             err;
        logic [DAT_W-1:0] dat;
        logic [3:0]       ack;
        logic [3:0]       e_vld;
        logic [3:0]       e_full;
        logic [3:0]       e_ovf;
        logic [1:0]       c_eng;
        logic             e_is_pop;
        logic             e_err;
        logic [DAT_W-1:0] e_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DAT_W-1:0] act, input logic [DAT_W-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic vld, input logic [1:0] eng, input logic is_pop,
                         input logic err, input logic [DAT_W-1:0] dat, input logic [3:0] ack);
        i_wrbk_vld    = vld;
        i_wrbk_engid  = eng;
        i_wrbk_is_pop = is_pop;
        i_wrbk_err    = err;
        i_wrbk_dat    = dat;
        i_rsp_ack     = ack;
    endtask

    // One clock with the given inputs; returns #1 after the edge with inputs idle.
    task automatic step(input logic vld, input logic [1:0] eng, input logic is_pop,
                        input logic err, input logic [DAT_W-1:0] dat, input logic [3:0] ack);
        drive(vld, eng, is_pop, err, dat, ack);
        @(posedge clk);
        #1;
        drive(1'b0, 2'd0, 1'b0, 1'b0, '0, 4'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " vld"},  DAT_W'(o_rsp_vld), '0);
        check({tag, " full"}, DAT_W'(o_ad_full), '0);
        check({tag, " ovf"},  DAT_W'(o_ovf_r),   '0);
        check({tag, " err"},  DAT_W'(o_rsp_err), '0);
        check({tag, " pop"},  DAT_W'(o_rsp_is_pop), '0);
        check({tag, " dat3"}, o_rsp_dat[3], '0);
        check({tag, " dat0"}, o_rsp_dat[0], '0);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        @(posedge clk);
        #1;
        arst = 1'b0;
    endtask

    initial begin
        arst = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0, '0, 4'b0);
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        arst = 1'b0;

        //            vld eng pop err dat                ack      e_vld    e_full   e_ovf    c_eng e_pop e_err e_dat
        vecs.push_back('{1, 1, 1, 0, DAT_W'(16'hDEAD), 4'b0000, 4'b0010, 4'b0000, 4'b0000, 1, 1, 0, DAT_W'(16'hDEAD)});
        vecs.push_back('{0, 0, 0, 0, '0,               4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 0, 0, '0});
        vecs.push_back('{1, 3, 0, 1, DAT_W'(16'hFFFF), 4'b0000, 4'b1000, 4'b0000, 4'b0000, 3, 0, 1, '0});
        vecs.push_back('{0, 0, 0, 0, '0,               4'b1000, 4'b0000, 4'b0000, 4'b0000, 3, 0, 0, '0});
        vecs.push_back('{1, 0, 1, 0, DAT_W'(8'h11),    4'b0000, 4'b0001, 4'b0000, 4'b0000, 0, 1, 0, DAT_W'(8'h11)});
        vecs.push_back('{1, 0, 1, 0, DAT_W'(8'h22),    4'b0000, 4'b0001, 4'b0001, 4'b0000, 0, 1, 0, DAT_W'(8'h11)});
        vecs.push_back('{1, 0, 1, 0, DAT_W'(8'h33),    4'b0000, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, DAT_W'(8'h11)});
        vecs.push_back('{1, 0, 1, 0, DAT_W'(8'h44),    4'b0001, 4'b0001, 4'b0001, 4'b0001, 0, 1, 0, DAT_W'(8'h22)});
        vecs.push_back('{0, 0, 0, 0, '0,               4'b0001, 4'b0001, 4'b0000, 4'b0001, 0, 1, 0, DAT_W'(8'h44)});
        vecs.push_back('{0, 0, 0, 0, '0,               4'b0001, 4'b0000, 4'b0000, 4'b0001, 0, 0, 0, '0});
        vecs.push_back('{0, 0, 0, 0, '0,               4'b0100, 4'b0000, 4'b0000, 4'b0001, 2, 0, 0, '0});
        vecs.push_back('{1, 0, 0, 0, DAT_W'(8'h55),    4'b0000, 4'b0001, 4'b0000, 4'b0001, 0, 0, 0, '0});
        vecs.push_back('{1, 1, 1, 1, DAT_W'(8'h66),    4'b0001, 4'b0010, 4'b0000, 4'b0001, 1, 1, 1, DAT_W'(8'h66)});
        vecs.push_back('{0, 0, 0, 0, '0,               4'b0010, 4'b0000, 4'b0000, 4'b0001, 1, 0, 0, '0});

        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vecs[i].vld, vecs[i].eng, vecs[i].is_pop, vecs[i].err, vecs[i].dat, vecs[i].ack);
            check({t, " vld"},    DAT_W'(o_rsp_vld), DAT_W'(vecs[i].e_vld));
            check({t, " full"},   DAT_W'(o_ad_full), DAT_W'(vecs[i].e_full));
            check({t, " ovf"},    DAT_W'(o_ovf_r),   DAT_W'(vecs[i].e_ovf));
            check({t, " is_pop"}, DAT_W'(o_rsp_is_pop[vecs[i].c_eng]), DAT_W'(vecs[i].e_is_pop));
            check({t, " err"},    DAT_W'(o_rsp_err[vecs[i].c_eng]),    DAT_W'(vecs[i].e_err));
            check({t, " dat"},    o_rsp_dat[vecs[i].c_eng], vecs[i].e_dat);
        end

        // Full engine 0 with simultaneous ack and write: accepted, no overflow.
        do_reset();
        step(1'b1, 2'd0, 1'b1, 1'b0, DAT_W'(1), 4'b0);
        step(1'b1, 2'd0, 1'b1, 1'b0, DAT_W'(2), 4'b0);
        check("ackwr full before", DAT_W'(o_ad_full[0]), 1);
        check("ackwr head 1st",    o_rsp_dat[0], DAT_W'(1));
        step(1'b1, 2'd0, 1'b1, 1'b0, DAT_W'(3), 4'b0001);
        check("ackwr full kept",   DAT_W'(o_ad_full[0]), 1);
        check("ackwr no ovf",      DAT_W'(o_ovf_r), 0);
        check("ackwr head 2nd",    o_rsp_dat[0], DAT_W'(2));
        step(1'b0, 2'd0, 1'b0, 1'b0, '0, 4'b0001);
        check("ackwr head 3rd",    o_rsp_dat[0], DAT_W'(3));
        check("ackwr not full",    DAT_W'(o_ad_full[0]), 0);
        step(1'b0, 2'd0, 1'b0, 1'b0, '0, 4'b0001);
        check("ackwr drained",     DAT_W'(o_rsp_vld), 0);

        // Engine 2: overlapped write/ack stream wraps both pointers several times.
        step(1'b1, 2'd2, 1'b1, 1'b0, DAT_W'(0), 4'b0);
        check("wrap head 0", o_rsp_dat[2], DAT_W'(0));
        for (int i = 1; i < 8; i++) begin
            step(1'b1, 2'd2, 1'b1, 1'b0, DAT_W'(i), 4'b0100);
            check($sformatf("wrap head %0d", i), o_rsp_dat[2], DAT_W'(i));
            check($sformatf("wrap vld %0d", i),  DAT_W'(o_rsp_vld), DAT_W'(4'b0100));
        end
        step(1'b0, 2'd0, 1'b0, 1'b0, '0, 4'b0100);
        check("wrap drained", DAT_W'(o_rsp_vld), 0);
        check("wrap no ovf",  DAT_W'(o_ovf_r), 0);

        // Mid-run reset with engines 0 and 3 occupied and engine 3 overflowed.
        step(1'b1, 2'd0, 1'b1, 1'b0, DAT_W'(8'hA0), 4'b0);
        step(1'b1, 2'd3, 1'b1, 1'b0, DAT_W'(8'hB0), 4'b0);
        step(1'b1, 2'd3, 1'b1, 1'b0, DAT_W'(8'hB1), 4'b0);
        step(1'b1, 2'd3, 1'b1, 1'b0, DAT_W'(8'hB2), 4'b0);
        check("prerst vld", DAT_W'(o_rsp_vld), DAT_W'(4'b1001));
        check("prerst ovf", DAT_W'(o_ovf_r),   DAT_W'(4'b1000));
        #2;
        arst = 1'b1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        arst = 1'b0;
        step(1'b1, 2'd3, 1'b1, 1'b0, DAT_W'(8'h77), 4'b0);
        check("postrst vld",  DAT_W'(o_rsp_vld), DAT_W'(4'b1000));
        check("postrst dat",  o_rsp_dat[3], DAT_W'(8'h77));
        check("postrst full", DAT_W'(o_ad_full), 0);
        check("postrst ovf",  DAT_W'(o_ovf_r), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
